pipe_stage_reg: RTL and testbench

Parametrised, flushable pipeline stage register for the pipelined MIPS datapath. It supersedes the fixed per-stage registers (ID/EX, EX/MEM, MEM/WB) with one generic block that has:
- a valid/ready handshake;
- a 2-entry skid buffer, so stalls do not create combinational ready paths;
- a flush that kills in-flight instructions;
- control gating, so bubbles never assert write enables downstream.

---
 rtl/pipe_pkg.sv | 33 +++
 rtl/pipe_stage_perf.sv | 26 ++
 rtl/pipe_stage_reg.sv | 133 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the pipelined MIPS datapath stage registers: occupancy state,
// default widths and the control-bundle bit layout every stage indexes.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_t;

  localparam int PIPE_DATA_W   = 32;
  localparam int PIPE_REG_W    = 5;
  localparam int PIPE_NUM_DATA = 3;

  // Control bundle layout, MSB first; reg_write is bit 7, branch is bit 0.
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_read;
    logic mem_write;
    logic pc_src;
    logic alu_src;
    logic reg_dst;
    logic branch;
  } mips_ctrl_t;

  localparam int PIPE_CTRL_W = $bits(mips_ctrl_t);

  function automatic logic ctrl_has_side_effect(input mips_ctrl_t c);
    return c.reg_write | c.mem_write;
  endfunction

endpackage

// File: rtl/pipe_stage_perf.sv
// Saturating stall / flush event counters for a pipeline stage register.
// Only instantiated when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_evt,
  input  logic        flush_evt,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_evt && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (flush_evt && (flush_cnt != 32'hFFFF_FFFF)) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic flushable pipeline stage register with a 2-entry skid buffer and
// control gating. Define PIPE_STAGE_PERF_EN to add stall_cnt / flush_cnt ports.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W   = PIPE_DATA_W,
  parameter int NUM_DATA = PIPE_NUM_DATA,
  parameter int CTRL_W   = PIPE_CTRL_W,
  parameter int REG_W    = PIPE_REG_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic [NUM_DATA*DATA_W-1:0] in_data,
  input  logic [REG_W-1:0]           in_rd,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [NUM_DATA*DATA_W-1:0] out_data,
  output logic [REG_W-1:0]           out_rd,
  output pipe_state_t                dbg_state
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]                stall_cnt,
  output logic [31:0]                flush_cnt
`endif
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both
  // high; once valid is raised, the payload holds until that edge. in_ready and
  // out_valid are pure flops, so no ready path crosses the stage combinationally.

  pipe_state_t                 state;
  logic                        ready_q;
  logic                        valid_q;

  logic [CTRL_W-1:0]           main_ctrl;
  logic [NUM_DATA*DATA_W-1:0]  main_data;
  logic [REG_W-1:0]            main_rd;
  logic [CTRL_W-1:0]           skid_ctrl;
  logic [NUM_DATA*DATA_W-1:0]  skid_data;
  logic [REG_W-1:0]            skid_rd;

  logic acc;
  logic pop;

  assign acc = in_valid & ready_q;
  assign pop = valid_q & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      main_ctrl <= '0;
      main_data <= '0;
      main_rd   <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
      skid_rd   <= '0;
    end else if (flush) begin
      // Payload registers keep stale contents; the ctrl gate hides them.
      state   <= EMPTY;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (acc) begin
            main_ctrl <= in_ctrl;
            main_data <= in_data;
            main_rd   <= in_rd;
            state     <= ONE;
            valid_q   <= 1'b1;
          end
        end
        ONE: begin
          if (pop && acc) begin
            main_ctrl <= in_ctrl;
            main_data <= in_data;
            main_rd   <= in_rd;
          end else if (pop) begin
            state   <= EMPTY;
            valid_q <= 1'b0;
          end else if (acc) begin
            // The younger entry parks in the skid slot; stop accepting.
            skid_ctrl <= in_ctrl;
            skid_data <= in_data;
            skid_rd   <= in_rd;
            state     <= TWO;
            ready_q   <= 1'b0;
          end
        end
        TWO: begin
          if (pop) begin
            main_ctrl <= skid_ctrl;
            main_data <= skid_data;
            main_rd   <= skid_rd;
            state     <= ONE;
            ready_q   <= 1'b1;
          end
        end
        default: begin
          state   <= EMPTY;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign out_ctrl  = main_ctrl & {CTRL_W{valid_q}};
  assign out_data  = main_data;
  assign out_rd    = main_rd;
  assign dbg_state = state;

`ifdef PIPE_STAGE_PERF_EN
  pipe_stage_perf u_perf (
    .clk       (clk),
    .rst       (rst),
    .stall_evt (valid_q & ~out_ready),
    .flush_evt (flush & (state != EMPTY)),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed streams, stalls, flush, gating
// and asynchronous reset; perf counters checked when PIPE_STAGE_PERF_EN is set.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int DATA_W   = 32;
  localparam int NUM_DATA = 3;
  localparam int CTRL_W   = 8;
  localparam int REG_W    = 5;
  localparam int DW       = NUM_DATA * DATA_W;
  localparam int W        = CTRL_W + DW + REG_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DW-1:0]     in_data;
  logic [REG_W-1:0]  in_rd;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DW-1:0]     out_data;
  logic [REG_W-1:0]  out_rd;
  pipe_state_t       dbg_state;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]       stall_cnt;
  logic [31:0]       flush_cnt;
`endif

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int seen   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  pipe_stage_reg dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .in_rd     (in_rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .out_rd    (out_rd),
    .dbg_state (dbg_state)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  // ---------------- helpers / driver ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input logic [31:0] v);
    return {v ^ 32'hFFFF_0000, v, v + 32'd1};
  endfunction

  task automatic send(input logic [CTRL_W-1:0] c, input logic [31:0] v,
                      input logic [REG_W-1:0] r, output int waits);
    waits    = 0;
    in_valid = 1'b1;
    in_ctrl  = c;
    in_data  = mk(v);
    in_rd    = r;
    @(negedge clk);
    while (!in_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) check("send_timeout", 0, 1);
    else exp_q.push_back({c, mk(v), r});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", {out_ctrl, out_data, out_rd}, 0);
      end else begin
        e = exp_q.pop_front();
        check("sb_entry", {out_ctrl, out_data, out_rd}, e);
        seen++;
      end
    end
    if (!rst && !out_valid) check("bubble_ctrl", out_ctrl, 0);
  end

  // ---------------- stimulus ----------------
  initial begin
    int w;
    int base;
    logic [31:0] stream_v [4];
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] s0;
    logic [31:0] f0;
`endif
    stream_v[0] = 32'h10; stream_v[1] = 32'h20; stream_v[2] = 32'h30; stream_v[3] = 32'h40;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0;
    in_data = '0; in_rd = '0; out_ready = 1'b0;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_ctrl", out_ctrl, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_rd", out_rd, 0);
    check("rst_state", dbg_state, EMPTY);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Stream four entries back to back.
    out_ready = 1'b1;
    base = seen;
    for (int i = 0; i < 4; i++) begin
      send(8'h80 | 8'(i), stream_v[i], 5'(i + 1), w);
      check("stream_in_ready", w, 0);
    end
    @(negedge clk); #1;
    check("stream_count_latency", seen - base, 4);
    tick();

    // Stall: fill both slots, then hold a third entry upstream.
    out_ready = 1'b0;
    base = seen;
    send(8'h11, 32'hA1, 5'd1, w);
    send(8'h12, 32'hA2, 5'd2, w);
    in_valid = 1'b1; in_ctrl = 8'h13; in_data = mk(32'hA3); in_rd = 5'd3;
    @(negedge clk);
    check("stall_state_two", dbg_state, TWO);
    check("stall_in_ready", in_ready, 0);
    check("stall_head", out_data[DATA_W +: DATA_W], 32'hA1);
    @(negedge clk);
    check("stall_hold_data", out_data[DATA_W +: DATA_W], 32'hA1);
    check("stall_hold_valid", out_valid, 1);
    tick();
    out_ready = 1'b1;
    send(8'h13, 32'hA3, 5'd3, w);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    check("stall_drain_count", seen - base, 3);
    check("stall_drain_empty", exp_q.size(), 0);
    tick();

    // Flush in TWO with a new entry offered.
    out_ready = 1'b0;
    send(8'hC1, 32'hB1, 5'd4, w);
    send(8'hC2, 32'hB2, 5'd5, w);
    in_valid = 1'b1; in_ctrl = 8'hFF; in_data = mk(32'h55); in_rd = 5'd9;
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("flush_out_valid", out_valid, 0);
    check("flush_out_ctrl", out_ctrl, 0);
    check("flush_in_ready", in_ready, 1);
    check("flush_state", dbg_state, EMPTY);
    tick();
    out_ready = 1'b1;
    base = seen;
    repeat (3) tick();
    check("flush_no_output", seen - base, 0);

    // Control gating on bubbles, then a valid entry carries its ctrl.
    in_valid = 1'b0; in_ctrl = 8'hFF;
    tick();
    @(negedge clk);
    check("gate_bubble_ctrl", out_ctrl, 8'h00);
    check("gate_bubble_valid", out_valid, 0);
    tick();
    send(8'h81, 32'h77, 5'd17, w);
    @(negedge clk);
    check("gate_valid_ctrl", out_ctrl, 8'h81);
    check("gate_valid_rd", out_rd, 17);
    tick();

    // Asynchronous reset while holding two entries.
    out_ready = 1'b0;
    send(8'hD1, 32'hC1, 5'd6, w);
    send(8'hD2, 32'hC2, 5'd7, w);
    check("pre_rst_state", dbg_state, TWO);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_out_ctrl", out_ctrl, 0);
    check("arst_out_data", out_data, 0);
    check("arst_out_rd", out_rd, 0);
    check("arst_state", dbg_state, EMPTY);
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick();

`ifdef PIPE_STAGE_PERF_EN
    // Seven stall cycles, then two flushes while non-empty and one while empty.
    out_ready = 1'b0;
    s0 = stall_cnt;
    f0 = flush_cnt;
    send(8'h01, 32'hE1, 5'd1, w);
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("perf_stall_cnt", stall_cnt - s0, 7);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    exp_q.delete();
    send(8'h02, 32'hE2, 5'd2, w);
    flush = 1'b1;
    tick();
    tick();
    flush = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("perf_flush_cnt", flush_cnt - f0, 2);
    tick();
`endif

    check("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
